// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: legality check, one registered request to a
// variable-latency data memory, pipeline stall until ack or timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemMemRead,
  input  logic        MemMemWrite,
  input  logic [63:0] MemALUOut,
  input  logic [63:0] MemDb,
  input  logic [3:0]  Memxfer_size,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  output logic [63:0] ld_data,
  output logic        stall,
  output logic        mem_fault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  size_q, size_d;
  logic [63:0] ld_q, ld_d;
  logic        fault_q, fault_d;

  logic access, size_ok, misalign, illegal, go, timeout_hit;

  always_comb begin
    access   = MemMemRead ^ MemMemWrite;
    size_ok  = 1'b0;
    misalign = 1'b0;
    case (Memxfer_size)
      4'd1: size_ok = 1'b1;
      4'd2: begin size_ok = 1'b1; misalign = MemALUOut[0]; end
      4'd4: begin size_ok = 1'b1; misalign = |MemALUOut[1:0]; end
      4'd8: begin size_ok = 1'b1; misalign = |MemALUOut[2:0]; end
      default: size_ok = 1'b0;
    endcase
    // A bubble (neither read nor write) is never a fault, whatever its size/address.
    illegal     = (MemMemRead & MemMemWrite) | (access & (~size_ok | misalign));
    go          = access & ~illegal;
    timeout_hit = (cnt_q == CNT_LAST) & ~mem_ack;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    ld_d    = ld_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = MemMemWrite;
          addr_d  = MemALUOut;
          wdata_d = MemDb;
          size_d  = Memxfer_size;
          cnt_d   = 8'd0;
        end else if (illegal) begin
          fault_d = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) ld_d = mem_rdata;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 4'd0;
      ld_q    <= 64'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      ld_q    <= ld_d;
      fault_q <= fault_d;
    end
  end

  // Reset gates stall directly so it falls with the async reset even if MEM still holds an access.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = go;
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
    stall = stall & ~reset;
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;
  assign ld_data   = ld_q;
  assign mem_fault = fault_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access sequencer for the 5-stage pipelined CPU. It sits between the EX/MEM pipeline register outputs and a variable-latency data memory with a req/ack handshake. It checks each load/store for legality, drives one registered memory request, and holds the pipeline with `stall` until the access completes or times out. Completed load data is returned on `ld_data` for the MEM/WB register.

## Interface
- `TIMEOUT`, 16: max cycles in REQ without `mem_ack` before aborting; legal range 2..255.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `MemMemRead`  in  1  load in MEM stage.
- `MemMemWrite`  in  1  store in MEM stage.
- `MemALUOut`  in  64  effective byte address.
- `MemDb`  in  64  store data.
- `Memxfer_size`  in  4  transfer size in bytes; legal values 1, 2, 4, 8.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  64  read data, valid when `mem_ack`=1 and `mem_we`=0.
- `mem_req`  out  1  request active, registered.
- `mem_we`  out  1  1 = write, registered.
- `mem_addr`  out  64  registered address.
- `mem_wdata`  out  64  registered write data.
- `mem_size`  out  4  registered transfer size.
- `ld_data`  out  64  last completed load data, held until the next load completes.
- `stall`  out  1  freeze IF/ID/EX and EX/MEM; combinational from state and inputs.
- `mem_fault`  out  1  one-cycle pulse on an illegal access or timeout, registered.

## Operation
- States: IDLE, REQ, DONE.
- access = `MemMemRead` XOR `MemMemWrite`.
- illegal = (`MemMemRead` AND `MemMemWrite`), OR a size not in {1,2,4,8}, OR misalignment (`MemALUOut` mod size ≠ 0) when access=1.
- IDLE, access=1 and legal:
  - `stall`=1 in the same cycle.
  - On the next edge, latch addr, wdata, size and we=`MemMemWrite`; set `mem_req`=1 and clear the timeout counter.
  - Go to REQ.
- IDLE, illegal:
  - No request; `stall`=0.
  - `mem_fault`=1 on the next cycle for exactly one cycle. The instruction advances and is squashed downstream.
- IDLE, neither read nor write: `stall`=0; stay in IDLE.
- REQ:
  - `stall`=1; `mem_req`, addr, wdata, size and we held stable.
  - Counter increments every REQ cycle without `mem_ack`.
- REQ, `mem_ack`=1:
  - If we=0, capture `mem_rdata` into `ld_data`.
  - Drop `mem_req`; go to DONE.
- REQ, counter = `TIMEOUT`-1 and no ack:
  - Drop `mem_req`; pulse `mem_fault`; go to DONE. `ld_data` is unchanged.
  - If ack and timeout fall in the same cycle, ack wins and there is no fault.
- DONE:
  - `stall`=0 so the pipeline advances exactly one instruction; go to IDLE unconditionally.
  - Inputs are not evaluated in DONE. This prevents re-issuing the instruction that just completed.
- `mem_ack` outside REQ is ignored.
- Counter width is 8 bits; it saturates and never wraps.

## Timing
- All outputs are 0 after reset, and state is IDLE.
- Async reset in REQ drops `mem_req` immediately, without waiting for a clock edge.
- Zero-wait access: cycle 0 IDLE (`stall`=1), cycle 1 REQ with ack, cycle 2 DONE (`stall`=0).
  - This gives 2 stall cycles.
  - `ld_data` is valid from cycle 2.
- N-cycle memory, with ack in the Nth REQ cycle: N+1 stall cycles.
- Timeout: `TIMEOUT`+1 stall cycles; `mem_fault` is high in the DONE cycle.
- Illegal access: 0 stall cycles; `mem_fault` is high the cycle after detection.
- Back-to-back accesses: earliest next request is issued 2 cycles after the previous ack cycle (DONE, then IDLE detect).

## Test plan
- Reset sequencing: assert `reset` mid-REQ, asynchronously between edges -> `mem_req`, `stall`, `mem_fault` and `ld_data` go to 0 immediately; after release, state is IDLE.
- Load, addr 0x40, size 8, `mem_ack` on the first REQ cycle with rdata 0xDEADBEEF_CAFEF00D -> `stall` high for 2 cycles; `ld_data` = that value in DONE; `mem_we`=0.
- Store, addr 0x104, size 4, data 0x1234, ack after 3 REQ cycles -> 4 stall cycles; addr, wdata, size and we=1 stable throughout REQ; `ld_data` unchanged.
- Misaligned load, addr 0x03, size 2 -> no `mem_req`; `stall`=0; `mem_fault`=1 for exactly one cycle.
- Illegal size: size 3, then read+write both set -> `mem_fault` on each; no request issued.
- With `TIMEOUT`=4 and no ack -> `mem_req` drops after 4 REQ cycles; `mem_fault` pulses.
  - Repeat with ack on the 4th REQ cycle -> no fault, data captured.
- Back-to-back loads held in MEM -> exactly one request per instruction; no duplicate request in the cycle after DONE.
